esm_issue_buffer: RTL
=====================

# esm_issue_buffer

Parametrised successor to the single-index ESM instruction buffer. It accepts decoded instructions over a valid/ready handshake and holds up to BS of them in an age-ordered buffer. Each cycle it issues the oldest hazard-free instruction into a registered output stage, using a per-register scoreboard with LAT-cycle write latency. It sits between fetch/decode and the execute stage, and permits out-of-order issue only when register dependencies allow it.

## Interface
- INSTR_W, 32, instruction width; must be at least 25.
- REGNUM, 32, architectural register count; RW = $clog2(REGNUM), at most 5.
- BS, 8, buffer depth; must be at least 2.
- LAT, 2, cycles a destination register stays busy after issue; 0 disables the scoreboard.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of buffer, output stage and scoreboard.
- in_valid  in  1  instr_in, alu_src and reg_write are valid.
- in_ready  out  1  buffer can accept an instruction; equals occupancy < BS and does not depend on the same-cycle issue.
- instr_in  in  INSTR_W  instruction; rd=[11:7], rs1=[19:15], rs2=[24:20], each truncated to RW bits.
- alu_src  in  1  1 means rs2 is not a source operand (immediate form).
- reg_write  in  1  1 means the instruction writes rd.
- out_valid  out  1  instr_out holds an issued instruction.
- out_ready  in  1  consumer accepts instr_out.
- instr_out  out  INSTR_W  issued instruction.
- occupancy  out  $clog2(BS+1)  number of valid buffer entries; the output stage is not counted.

## Operation
- Reset: out_valid=0, instr_out=0, occupancy=0, in_ready=1, all scoreboard counters=0.
- Enqueue happens when in_valid & in_ready. The new entry is appended behind the youngest valid entry, so entry 0 is always the oldest.
- Sources of an entry: rs1, plus rs2 when alu_src=0. Destination: rd when reg_write=1. Register 0 is never a source or destination for hazard purposes.
- An entry is eligible when all three hold:
  - none of its sources has a non-zero scoreboard counter;
  - no older valid entry has a destination equal to one of its sources (RAW);
  - if it has a destination, no older valid entry reads or writes that register (WAR/WAW).
- Issue slot is free when out_valid=0, or out_valid & out_ready.
- When the slot is free, the oldest eligible entry moves to instr_out and out_valid=1. Younger entries compact toward index 0 on the same edge. If no entry is eligible, out_valid goes to 0 when the slot empties.
- On issue with a destination, that register's counter is loaded with LAT.
- Counter rules:
  - Each non-zero counter decrements by 1 per cycle.
  - All counters freeze while out_valid & !out_ready.
  - A load on the same edge overrides the decrement.
- Entry 0 only waits on the scoreboard, which always drains, so the block cannot deadlock.
- Enqueue and issue on the same edge are allowed. Occupancy changes by +1, -1 or 0. A newly enqueued entry is not eligible until the next cycle.
- flush has priority over enqueue and issue. On the next edge the buffer is empty, out_valid=0, counters=0, and in_valid that cycle is dropped.
- Reset asserted mid-operation discards everything immediately, including the output stage.

## Timing
- Minimum latency: an instruction enqueued at edge N appears on instr_out after edge N+1.
- Peak rate is one enqueue and one issue per cycle.
- A dependent instruction issues no earlier than LAT+1 edges after its producer issues, counting non-stalled cycles only.
- With out_ready held low, one instruction sits in the output stage and BS more fill the buffer: BS+1 accepted in total, then in_ready=0.
- in_ready, out_valid and instr_out are driven from registers or occupancy only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- Reset: pull rst low during traffic. Required: out_valid=0, instr_out=0, occupancy=0 and in_ready=1 asynchronously, and the next enqueue behaves as if the block were fresh.
- In-order stream: LAT=2, out_ready=1, three instructions with no dependencies on consecutive cycles. Required: they leave in order on consecutive cycles, the first two edges after its in_valid.
- RAW reorder: A writes x5, B reads x5 as rs1, C is independent (x6→x7). Required: issue order A, C, B, with B issued 3 edges after A.
- Immediate and x0: B reads x5 as rs2 with alu_src=1 behind a writer of x5, and D writes x0 ahead of an x0 reader. Required: no stalls; B and D's consumer issue back-to-back.
- Full and backpressure: out_ready=0, in_valid held high. Required: 9 accepted with BS=8, then in_ready=0 and occupancy=8. Release out_ready: one issue per cycle, in_ready=1 on the following cycle.
- Flush collision: assert flush together with in_valid while a stall is in progress. Required: next cycle out_valid=0, occupancy=0, the flushed-cycle instruction is lost, and a subsequent reader of a busy register issues without waiting.

Source files
------------

// File: rtl/esm_issue_buffer.sv
// esm_issue_buffer: age-ordered issue buffer with per-register scoreboard.
// Ports: clk/rst, flush, in_* enqueue handshake, out_* issue stage, occupancy.
module esm_issue_buffer #(
  parameter int INSTR_W = 32,
  parameter int REGNUM  = 32,
  parameter int BS      = 8,
  parameter int LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INSTR_W-1:0]      instr_in,
  input  logic                    alu_src,
  input  logic                    reg_write,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      instr_out,
  output logic [$clog2(BS+1)-1:0] occupancy
);
  localparam int RW = $clog2(REGNUM);
  localparam int NR = 1 << RW;
  localparam int OW = $clog2(BS + 1);
  localparam int SW = $clog2(BS);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               imm;
    logic               wr;
  } ent_t;

  ent_t               ent_q [BS];
  ent_t               ent_d [BS];
  logic [OW-1:0]      cnt_q, cnt_d;
  logic               ov_q, ov_d;
  logic [INSTR_W-1:0] out_q, out_d;
  logic [CW-1:0]      sb_q [NR];
  logic [CW-1:0]      sb_d [NR];

  logic [BS-1:0] elig;
  logic          found;
  logic [SW-1:0] sel;
  logic          stall, slot_free, issue, enq;
  logic [OW-1:0] wp;
  ent_t          sel_e, new_e;

  function automatic logic [RW-1:0] f_rd(ent_t e);
    return e.instr[7 +: RW];
  endfunction

  function automatic logic [RW-1:0] f_rs1(ent_t e);
    return e.instr[15 +: RW];
  endfunction

  function automatic logic [RW-1:0] f_rs2(ent_t e);
    return e.instr[20 +: RW];
  endfunction

  function automatic logic f_s1v(ent_t e);
    return f_rs1(e) != '0;
  endfunction

  function automatic logic f_s2v(ent_t e);
    return !e.imm && (f_rs2(e) != '0);
  endfunction

  function automatic logic f_dv(ent_t e);
    return e.wr && (f_rd(e) != '0);
  endfunction

  // o is older than y: RAW, WAR or WAW blocks y
  function automatic logic f_conf(ent_t o, ent_t y);
    logic raw, war;
    raw = f_dv(o) &&
          ((f_s1v(y) && f_rd(o) == f_rs1(y)) ||
           (f_s2v(y) && f_rd(o) == f_rs2(y)));
    war = f_dv(y) &&
          ((f_s1v(o) && f_rs1(o) == f_rd(y)) ||
           (f_s2v(o) && f_rs2(o) == f_rd(y)) ||
           (f_dv(o)  && f_rd(o)  == f_rd(y)));
    return raw || war;
  endfunction

  assign new_e     = {instr_in, alu_src, reg_write};
  assign in_ready  = cnt_q < OW'(BS);
  assign enq       = in_valid & in_ready;
  assign stall     = ov_q & ~out_ready;
  assign slot_free = ~stall;
  assign issue     = slot_free & found;
  assign wp        = cnt_q - OW'(issue);
  assign sel_e     = ent_q[sel];

  assign out_valid = ov_q;
  assign instr_out = out_q;
  assign occupancy = cnt_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < BS; i++) begin
      elig[i] = OW'(i) < cnt_q;
      if (f_s1v(ent_q[i]) && sb_q[f_rs1(ent_q[i])] != '0)
        elig[i] = 1'b0;
      if (f_s2v(ent_q[i]) && sb_q[f_rs2(ent_q[i])] != '0)
        elig[i] = 1'b0;
      for (int j = 0; j < i; j++)
        if (f_conf(ent_q[j], ent_q[i]))
          elig[i] = 1'b0;
    end
  end

  // descending scan leaves the oldest eligible index in sel
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = BS - 1; i >= 0; i--)
      if (elig[i]) begin
        found = 1'b1;
        sel   = SW'(i);
      end
  end

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      if (issue)
        for (int k = 0; k < BS; k++)
          if (k >= int'(sel))
            ent_d[k] = ent_q[(k + 1) % BS];
      if (enq)
        for (int k = 0; k < BS; k++)
          if (OW'(k) == wp)
            ent_d[k] = new_e;
      cnt_d = cnt_q + OW'(enq) - OW'(issue);
    end
  end

  always_comb begin
    ov_d  = ov_q;
    out_d = out_q;
    if (flush) begin
      ov_d  = 1'b0;
      out_d = '0;
    end else if (slot_free) begin
      ov_d = found;
      if (found)
        out_d = sel_e.instr;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      for (int r = 0; r < NR; r++)
        sb_d[r] = '0;
    end else if (!stall) begin
      for (int r = 0; r < NR; r++)
        if (sb_q[r] != '0)
          sb_d[r] = sb_q[r] - 1'b1;
      if (issue && f_dv(sel_e))
        sb_d[f_rd(sel_e)] = CW'(LAT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BS; k++)
        ent_q[k] <= '0;
      for (int r = 0; r < NR; r++)
        sb_q[r] <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      out_q <= '0;
    end else begin
      ent_q <= ent_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      out_q <= out_d;
    end
  end

endmodule
